// File: rtl/intr_sched_if.sv
// Bus between the interrupt scheduler and its CPU-side user.
// The master drives requests and control; the slave is the scheduler.
interface intr_sched_if #(
  parameter int N_IRQ = 8
);
  logic [N_IRQ-1:0] irq;
  logic             boundary;
  logic             mask_we;
  logic [N_IRQ-1:0] mask_d;
  logic             ie_set;
  logic             ie_clr;
  logic             reti;
  logic             take;
  logic [N_IRQ-1:0] intr;
  logic             s_intr;
  logic [N_IRQ-1:0] pending;
  logic [N_IRQ-1:0] mask;
  logic             ie;

  modport master (
    output irq, boundary, mask_we, mask_d, ie_set, ie_clr, reti,
    input  take, intr, s_intr, pending, mask, ie
  );

  modport slave (
    input  irq, boundary, mask_we, mask_d, ie_set, ie_clr, reti,
    output take, intr, s_intr, pending, mask, ie
  );
endinterface

// File: rtl/intr_sched.sv
// Interrupt scheduler: synchronizes and edge-detects irq lines, masks and
// priority-arbitrates pending requests, and grants one at an instruction boundary.
module intr_sched #(
  parameter int N_IRQ       = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  intr_sched_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    TAKE    = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [N_IRQ-1:0] sync_out;
  logic [N_IRQ-1:0] sync_prev_q;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] pending_q;
  logic [N_IRQ-1:0] mask_q;
  logic             ie_q;
  logic [N_IRQ-1:0] intr_q;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] winner;
  logic             grant;

  generate
    if (SYNC_STAGES == 0) begin : g_no_sync
      assign sync_out = bus.irq;
    end else begin : g_sync
      logic [N_IRQ-1:0] stage_q [SYNC_STAGES];

      // NOTE: every synchronizer stage is reset explicitly; a stale 1 left in
      // the chain would look like a fresh rising edge right after reset.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < SYNC_STAGES; i++) stage_q[i] <= '0;
        end else begin
          stage_q[0] <= bus.irq;
          for (int i = 1; i < SYNC_STAGES; i++) stage_q[i] <= stage_q[i-1];
        end
      end

      assign sync_out = stage_q[SYNC_STAGES-1];
    end
  endgenerate

  assign rise     = sync_out & ~sync_prev_q;
  assign eligible = pending_q & mask_q;
  // Isolating the lowest set bit gives bit 0 the highest priority.
  assign winner   = eligible & (-eligible);
  assign grant    = (state_q == IDLE) && bus.boundary && ie_q && (eligible != '0);

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: the default assignment first keeps this combinational block latch-free.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant) state_d = TAKE;
      TAKE:    state_d = SERVICE;
      SERVICE: if (bus.reti) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.take   = 1'b0;
    bus.s_intr = 1'b0;
    case (state_q)
      TAKE: begin
        bus.take   = 1'b1;
        bus.s_intr = 1'b1;
      end
      SERVICE: bus.s_intr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_prev_q <= '0;
      pending_q   <= '0;
      mask_q      <= '0;
      ie_q        <= 1'b0;
      intr_q      <= '0;
    end else begin
      sync_prev_q <= sync_out;
      // A new edge on the granted line survives its own clear.
      pending_q   <= (pending_q & ~(grant ? winner : '0)) | rise;
      if (bus.mask_we) mask_q <= bus.mask_d;
      if (bus.ie_clr)      ie_q <= 1'b0;
      else if (bus.ie_set) ie_q <= 1'b1;
      if (grant)                                intr_q <= winner;
      else if (state_q == SERVICE && bus.reti) intr_q <= '0;
    end
  end

  assign bus.intr    = intr_q;
  assign bus.pending = pending_q;
  assign bus.mask    = mask_q;
  assign bus.ie      = ie_q;

endmodule

// File: tb/tb_intr_sched.sv
// Self-checking bench for intr_sched: directed scenarios followed by random
// traffic, all compared every cycle against a behavioural reference model.
module tb_intr_sched;
  localparam int N = 8;
  localparam int S = 2;

  logic clk = 1'b0;
  logic reset;
  int   vectors    = 0;
  int   miscompares = 0;

  intr_sched_if #(.N_IRQ(N)) bus ();

  intr_sched #(.N_IRQ(N), .SYNC_STAGES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Reference model state.
  logic [N-1:0] hist [S+1];
  int           phase;          // 0 idle, 1 just granted, 2 being serviced
  logic [N-1:0] m_pending, m_mask, m_intr;
  logic         m_ie;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] delayed_irq(input int d, input logic [N-1:0] cur);
    return (d == 0) ? cur : hist[d-1];
  endfunction

  task automatic model_edge();
    logic [N-1:0] now_v, prev_v, rise_v, elig;
    int           w;
    bit           g;
    if (reset) begin
      for (int i = 0; i <= S; i++) hist[i] = '0;
      phase = 0; m_pending = '0; m_mask = '0; m_intr = '0; m_ie = 1'b0;
      return;
    end
    now_v  = delayed_irq(S, bus.irq);
    prev_v = delayed_irq(S + 1, bus.irq);
    rise_v = now_v & ~prev_v;
    elig   = m_pending & m_mask;
    w = -1;
    for (int k = N - 1; k >= 0; k--) if (elig[k]) w = k;
    g = (phase == 0) && bus.boundary && m_ie && (w >= 0);
    if (g) begin
      m_pending[w] = 1'b0;
      m_intr       = N'(1) << w;
    end else if (phase == 2 && bus.reti) begin
      m_intr = '0;
    end
    m_pending = m_pending | rise_v;
    if (bus.mask_we) m_mask = bus.mask_d;
    if (bus.ie_clr) m_ie = 1'b0;
    else if (bus.ie_set) m_ie = 1'b1;
    if (phase == 0 && g) phase = 1;
    else if (phase == 1) phase = 2;
    else if (phase == 2 && bus.reti) phase = 0;
    for (int i = S; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = bus.irq;
  endtask

  task automatic compare_all();
    check("take",    32'(bus.take),    32'(phase == 1));
    check("s_intr",  32'(bus.s_intr),  32'(phase != 0));
    check("intr",    32'(bus.intr),    32'(m_intr));
    check("pending", 32'(bus.pending), 32'(m_pending));
    check("mask",    32'(bus.mask),    32'(m_mask));
    check("ie",      32'(bus.ie),      32'(m_ie));
  endtask

  task automatic cyc(input logic [N-1:0] i_irq, input logic bnd, input logic mwe,
                     input logic [N-1:0] md, input logic ies, input logic iec,
                     input logic rt, input logic rst);
    @(negedge clk);
    bus.irq = i_irq; bus.boundary = bnd; bus.mask_we = mwe; bus.mask_d = md;
    bus.ie_set = ies; bus.ie_clr = iec; bus.reti = rt; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc('0, 0, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic boundary_cyc();
    cyc('0, 1, 0, '0, 0, 0, 0, 0);
  endtask

  task automatic reti_cyc();
    cyc('0, 0, 0, '0, 0, 0, 1, 0);
  endtask

  task automatic pulse(input logic [N-1:0] lines);
    cyc(lines, 0, 0, '0, 0, 0, 0, 0);
    idle(S);
  endtask

  task automatic do_reset_and_enable(input logic [N-1:0] m);
    cyc('0, 0, 0, '0, 0, 0, 0, 1);
    cyc('0, 0, 1, m, 1, 0, 0, 0);
  endtask

  initial begin
    bus.irq = '0; bus.boundary = 0; bus.mask_we = 0; bus.mask_d = '0;
    bus.ie_set = 0; bus.ie_clr = 0; bus.reti = 0; reset = 1;
    for (int i = 0; i <= S; i++) hist[i] = '0;
    phase = 0; m_pending = '0; m_mask = '0; m_intr = '0; m_ie = 0;

    // Reset values
    cyc('0, 0, 0, '0, 0, 0, 0, 1);
    check("rst_intr", 32'(bus.intr), 32'h0);
    check("rst_ie",   32'(bus.ie),   32'h0);

    // 1: single request, latency and grant
    cyc('0, 0, 1, 8'hFF, 1, 0, 0, 0);
    cyc(8'h08, 0, 0, '0, 0, 0, 0, 0);
    idle(S - 1);
    check("t1_pend_early", 32'(bus.pending), 32'h00);
    idle(1);
    check("t1_pend_set", 32'(bus.pending), 32'h08);
    boundary_cyc();
    check("t1_take", 32'(bus.take), 32'h1);
    check("t1_intr", 32'(bus.intr), 32'h08);
    check("t1_pend_clr", 32'(bus.pending), 32'h00);
    boundary_cyc();
    check("t1_take_once", 32'(bus.take), 32'h0);
    reti_cyc();
    idle(1);

    // 2: simultaneous requests, priority order
    pulse(8'h24);
    boundary_cyc();
    check("t2_first", 32'(bus.intr), 32'h04);
    idle(2); reti_cyc(); boundary_cyc();
    check("t2_second", 32'(bus.intr), 32'h20);
    idle(1); reti_cyc(); idle(1);

    // 3: masked request persists, unmask releases it
    cyc('0, 0, 1, 8'hFE, 0, 0, 0, 0);
    pulse(8'h01);
    for (int i = 0; i < 20; i++) boundary_cyc();
    check("t3_masked", 32'(bus.pending), 32'h01);
    cyc('0, 0, 1, 8'h01, 0, 0, 0, 0);
    boundary_cyc();
    check("t3_grant", 32'(bus.intr), 32'h01);
    idle(1); reti_cyc();
    cyc('0, 0, 1, 8'hFF, 0, 0, 0, 0);

    // 4: request during service waits for return plus a later boundary
    pulse(8'h02);
    boundary_cyc();
    pulse(8'h01);
    boundary_cyc();
    check("t4_held", 32'(bus.intr), 32'h02);
    cyc('0, 1, 0, '0, 0, 0, 1, 0);
    check("t4_ret", 32'(bus.s_intr), 32'h0);
    boundary_cyc();
    check("t4_next", 32'(bus.intr), 32'h01);
    idle(1); reti_cyc(); idle(1);

    // 5: edge coinciding with the grant of the same line
    pulse(8'h10);
    cyc(8'h10, 0, 0, '0, 0, 0, 0, 0);
    idle(S - 1);
    boundary_cyc();
    check("t5_take", 32'(bus.intr), 32'h10);
    check("t5_repend", 32'(bus.pending), 32'h10);
    idle(1); reti_cyc(); boundary_cyc();
    check("t5_again", 32'(bus.intr), 32'h10);
    idle(1); reti_cyc(); idle(1);

    // 6: reset during service discards everything
    cyc('0, 0, 1, 8'h40, 0, 0, 0, 0);
    pulse(8'h40);
    boundary_cyc();
    pulse(8'h03);
    check("t6_pend", 32'(bus.pending), 32'h03);
    check("t6_intr", 32'(bus.intr), 32'h40);
    cyc('0, 0, 0, '0, 0, 0, 0, 1);
    check("t6_intr_rst", 32'(bus.intr), 32'h0);
    check("t6_pend_rst", 32'(bus.pending), 32'h0);
    check("t6_sintr_rst", 32'(bus.s_intr), 32'h0);
    reti_cyc();
    check("t6_reti_idle", 32'(bus.s_intr), 32'h0);

    // Random traffic
    do_reset_and_enable(8'hFF);
    begin
      logic [N-1:0] lvl;
      lvl = '0;
      for (int c = 0; c < 3000; c++) begin
        for (int k = 0; k < N; k++) if ($urandom_range(0, 9) == 0) lvl[k] = ~lvl[k];
        cyc(lvl,
            1'($urandom_range(0, 2) == 0),
            1'($urandom_range(0, 15) == 0),
            N'($urandom),
            1'($urandom_range(0, 4) == 0),
            1'($urandom_range(0, 19) == 0),
            1'($urandom_range(0, 5) == 0),
            1'($urandom_range(0, 299) == 0));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/intr_sched.md
Name: intr_sched

Overview:
- Interrupt scheduler for the single-cycle CPU datapath (cd).
- Captures rising edges on external interrupt lines into a pending register, masks and fixed-priority arbitrates them, and grants one interrupt at an instruction boundary.
- Drives the one-hot intr vector and the s_intr service flag into the datapath.
- Gives the control unit a one-cycle take pulse, on which the control unit asserts push and s_inc=2'b10.

Parameters:
N_IRQ, 8, number of interrupt lines; intr/mask/pending width. Fixed at 8 for cd's intr port.
SYNC_STAGES, 2, synchronizer flops per irq line before edge detection (0 = none).

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high
irq  input  N_IRQ  raw interrupt lines; rising edge = request
boundary  input  1  high in the last cycle of an instruction, when PC may be redirected
mask_we  input  1  write mask register from mask_d
mask_d  input  N_IRQ  new mask value; 1 = line enabled
ie_set  input  1  set global enable
ie_clr  input  1  clear global enable
reti  input  1  return-from-interrupt decoded by the control unit
take  output  1  one-cycle grant pulse; control unit pushes PC and selects vector
intr  output  N_IRQ  one-hot granted line to cd; zero when not TAKE/SERVICE
s_intr  output  1  high while in TAKE or SERVICE; selects the interrupt z flag in cd
pending  output  N_IRQ  pending register (status)
mask  output  N_IRQ  mask register (status)
ie  output  1  global enable (status)

Behaviour:
- Reset (sync): state=IDLE, pending=0, mask=0, ie=0, synchronizer and edge flops=0, intr=0, take=0, s_intr=0.
- Edge detect:
  - Line k's synchronized value is 1 now and 0 the previous cycle → set pending[k] next edge.
  - Latency from irq rise to pending set = SYNC_STAGES+1 cycles.
  - Levels held high do not re-trigger.
- Eligible vector: pending & mask. Winner = lowest-index set bit (bit 0 highest priority).
- States: IDLE, TAKE, SERVICE.
  - IDLE → TAKE when boundary=1, ie=1, eligible≠0, all sampled on the same edge.
    - On this edge, register the winner one-hot into intr and clear pending[winner].
  - TAKE lasts exactly 1 cycle:
    - take=1, s_intr=1, intr=winner.
    - Then → SERVICE unconditionally; boundary and reti are ignored in TAKE.
  - SERVICE: s_intr=1, intr held, take=0. No nesting; new requests only accumulate in pending.
    - reti=1 → IDLE next edge, with intr=0 and s_intr=0.
- reti in IDLE is ignored.
- take, s_intr and intr are registered outputs (state-decoded from flops). They change only on clock edges.
- Mask and enable:
  - mask_we loads mask next edge, in any state.
  - ie_set and ie_clr both high: ie_clr wins.
  - ie=0 blocks new grants but does not abort TAKE or SERVICE.
- Simultaneity:
  - A new edge on line k in the same cycle pending[k] is cleared by a grant: set wins, so pending[k]=1 afterwards (request not lost).
  - reti and boundary in the same SERVICE cycle: return only. Re-arbitration needs a later boundary in IDLE, so a minimum of 1 IDLE cycle separates services.
  - mask_we in the grant cycle: arbitration uses the old mask.
- Masked pending bits persist until granted or reset. Repeated edges on a pending line coalesce; there is no counting.
- Reset asserted mid-TAKE or mid-SERVICE: everything returns to reset values next edge, pending requests discarded.

Test Plan:
1. Reset, mask=8'hFF, ie=1; pulse irq[3] → pending=8'h08 after SYNC_STAGES+1 cycles; at next boundary: take=1 for 1 cycle, intr=8'h08, s_intr=1, pending=8'h00.
2. irq[5] and irq[2] rise in the same cycle, mask=8'hFF → first grant intr=8'h04; reti; next boundary grants intr=8'h20.
3. mask=8'hFE, irq[0] pulse → no take for 20 boundaries, pending=8'h01; write mask=8'h01 → grant intr=8'h01 at next boundary.
4. During SERVICE of line 1, pulse irq[0] → no take, intr stays 8'h02; after reti plus 1 IDLE cycle and a boundary → intr=8'h01.
5. Edge on irq[4] coincides with its grant edge → after take, pending=8'h10; second service of line 4 occurs.
6. Reset asserted in SERVICE (intr=8'h40) with pending=8'h03 → next cycle intr=0, s_intr=0, pending=0, mask=0, ie=0; reti in IDLE afterwards has no effect.
